// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller beside decode: load-use stalls, multi-cycle unit
// hold/issue, branch/trap flush, and a stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CNT_SAT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dec_valid_i,
  input  logic            dec_rs1_v_i,
  input  logic [4:0]      dec_rs1_adr_i,
  input  logic            dec_rs2_v_i,
  input  logic [4:0]      dec_rs2_adr_i,
  input  logic            dec_mc_req_i,
  input  logic            exe_load_v_q_i,
  input  logic [4:0]      exe_rd_adr_q_i,
  input  logic            mc_done_i,
  input  logic            branch_v_q_i,
  input  logic            trap_i,
  output logic            stall_o,
  output logic            bubble_o,
  output logic            flush_o,
  output logic            mc_start_o,
  output logic            mc_abort_o,
  output logic            mc_issue_o,
  output logic [XLEN-1:0] stall_cnt_q_o
);

  localparam bit SAT = (CNT_SAT != 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MC_ISSUE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rs1_hit, rs2_hit, lu;

  assign rs1_hit = dec_rs1_v_i && (dec_rs1_adr_i == exe_rd_adr_q_i);
  assign rs2_hit = dec_rs2_v_i && (dec_rs2_adr_i == exe_rd_adr_q_i);
  assign lu      = exe_load_v_q_i && (exe_rd_adr_q_i != 5'd0) && dec_valid_i
                   && (rs1_hit || rs2_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // Next state and combinational controls; everything reads 0 while in reset.
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    bubble_o   = 1'b0;
    flush_o    = 1'b0;
    mc_start_o = 1'b0;
    mc_abort_o = 1'b0;
    mc_issue_o = 1'b0;
    if (!reset_n) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_v_q_i || trap_i) begin
            flush_o = 1'b1;
          end else if (dec_valid_i && dec_mc_req_i && !lu) begin
            mc_start_o = 1'b1;
            stall_o    = 1'b1;
            bubble_o   = 1'b1;
            state_d    = MC_BUSY;
          end else if (lu) begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
          end
        end
        MC_BUSY: begin
          // A branch here is impossible by construction; handled as a trap.
          if (trap_i || branch_v_q_i) begin
            flush_o    = 1'b1;
            mc_abort_o = 1'b1;
            state_d    = RUN;
          end else begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
            if (mc_done_i) state_d = MC_ISSUE;
          end
        end
        MC_ISSUE: begin
          state_d = RUN;
          if (trap_i || branch_v_q_i) flush_o    = 1'b1;
          else                        mc_issue_o = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Stall-cycle counter: saturating or wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q_o <= '0;
    end else if (stall_o && !(SAT && (&stall_cnt_q_o))) begin
      stall_cnt_q_o <= stall_cnt_q_o + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors go through a scoreboard
// queue; three instances (32-bit saturating, 4-bit saturating, 4-bit wrapping).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dec_valid, rs1_v, rs2_v, mc_req, exe_load_v, mc_done, branch_v, trap;
  logic [4:0] rs1_adr, rs2_adr, rd_adr;

  logic [5:0]  o_main, o_sat, o_wrap;
  logic [31:0] cnt_main;
  logic [3:0]  cnt_sat, cnt_wrap;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int exp_sat = 0;
  int exp_wrap = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(32), .CNT_SAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .dec_valid_i(dec_valid), .dec_rs1_v_i(rs1_v),
    .dec_rs1_adr_i(rs1_adr), .dec_rs2_v_i(rs2_v), .dec_rs2_adr_i(rs2_adr),
    .dec_mc_req_i(mc_req), .exe_load_v_q_i(exe_load_v), .exe_rd_adr_q_i(rd_adr),
    .mc_done_i(mc_done), .branch_v_q_i(branch_v), .trap_i(trap),
    .stall_o(o_main[5]), .bubble_o(o_main[4]), .flush_o(o_main[3]),
    .mc_start_o(o_main[2]), .mc_abort_o(o_main[1]), .mc_issue_o(o_main[0]),
    .stall_cnt_q_o(cnt_main));

  pipe_ctrl #(.XLEN(4), .CNT_SAT(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .dec_valid_i(dec_valid), .dec_rs1_v_i(rs1_v),
    .dec_rs1_adr_i(rs1_adr), .dec_rs2_v_i(rs2_v), .dec_rs2_adr_i(rs2_adr),
    .dec_mc_req_i(mc_req), .exe_load_v_q_i(exe_load_v), .exe_rd_adr_q_i(rd_adr),
    .mc_done_i(mc_done), .branch_v_q_i(branch_v), .trap_i(trap),
    .stall_o(o_sat[5]), .bubble_o(o_sat[4]), .flush_o(o_sat[3]),
    .mc_start_o(o_sat[2]), .mc_abort_o(o_sat[1]), .mc_issue_o(o_sat[0]),
    .stall_cnt_q_o(cnt_sat));

  pipe_ctrl #(.XLEN(4), .CNT_SAT(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .dec_valid_i(dec_valid), .dec_rs1_v_i(rs1_v),
    .dec_rs1_adr_i(rs1_adr), .dec_rs2_v_i(rs2_v), .dec_rs2_adr_i(rs2_adr),
    .dec_mc_req_i(mc_req), .exe_load_v_q_i(exe_load_v), .exe_rd_adr_q_i(rd_adr),
    .mc_done_i(mc_done), .branch_v_q_i(branch_v), .trap_i(trap),
    .stall_o(o_wrap[5]), .bubble_o(o_wrap[4]), .flush_o(o_wrap[3]),
    .mc_start_o(o_wrap[2]), .mc_abort_o(o_wrap[1]), .mc_issue_o(o_wrap[0]),
    .stall_cnt_q_o(cnt_wrap));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    dec_valid = 1'b0; rs1_v = 1'b0; rs2_v = 1'b0; mc_req = 1'b0;
    exe_load_v = 1'b0; mc_done = 1'b0; branch_v = 1'b0; trap = 1'b0;
    rs1_adr = 5'd0; rs2_adr = 5'd0; rd_adr = 5'd0;
  endtask

  // Expected vector order: {stall, bubble, flush, mc_start, mc_abort, mc_issue}.
  task automatic expect_out(input string tag, input logic [5:0] e);
    logic [5:0] want;
    exp_q.push_back(e);
    if (e[5]) begin
      exp_cnt++;
      exp_sat  = (exp_sat == 15) ? 15 : exp_sat + 1;
      exp_wrap = (exp_wrap + 1) % 16;
    end
    #1;
    want = exp_q.pop_front();
    n_cmp++;
    assert ({o_main, o_sat, o_wrap} === {want, want, want}) else begin
      n_fail++;
      $error("FAIL %s: observed %b/%b/%b expected %b", tag, o_main, o_sat, o_wrap, want);
    end
  endtask

  task automatic check_cnt(input string tag);
    n_cmp++;
    assert (cnt_main === 32'(exp_cnt)) else begin
      n_fail++;
      $error("FAIL %s_cnt32: observed %0d expected %0d", tag, cnt_main, exp_cnt);
    end
    n_cmp++;
    assert (cnt_sat === 4'(exp_sat)) else begin
      n_fail++;
      $error("FAIL %s_cnt_sat: observed %0d expected %0d", tag, cnt_sat, exp_sat);
    end
    n_cmp++;
    assert (cnt_wrap === 4'(exp_wrap)) else begin
      n_fail++;
      $error("FAIL %s_cnt_wrap: observed %0d expected %0d", tag, cnt_wrap, exp_wrap);
    end
  endtask

  task automatic set_mc_lu_rs2();
    clr_in();
    dec_valid = 1'b1; mc_req = 1'b1; rs2_v = 1'b1; rs2_adr = 5'd9;
    rs1_v = 1'b1; rs1_adr = 5'd3; exe_load_v = 1'b1; rd_adr = 5'd9;
  endtask

  initial begin
    reset_n = 1'b0;
    clr_in();

    // Reset: outputs forced low even with active requests
    tick(); dec_valid = 1'b1; mc_req = 1'b1; branch_v = 1'b1;
    expect_out("reset_outs", 6'b000000);
    check_cnt("reset");
    tick(); clr_in(); reset_n = 1'b1;
    expect_out("idle", 6'b000000);

    // Load-use on rs1, then bubble in EXE clears it
    tick(); dec_valid = 1'b1; rs1_v = 1'b1; rs1_adr = 5'd5; exe_load_v = 1'b1; rd_adr = 5'd5;
    expect_out("lu_rs1", 6'b110000);
    tick(); exe_load_v = 1'b0;
    expect_out("lu_clear", 6'b000000);
    check_cnt("lu");
    // rd = x0 never hazards
    tick(); rs1_adr = 5'd0; exe_load_v = 1'b1; rd_adr = 5'd0;
    expect_out("lu_x0", 6'b000000);
    // rs2 hazard, rs1 unrelated
    tick(); rs1_adr = 5'd1; rs2_v = 1'b1; rs2_adr = 5'd7; rd_adr = 5'd7;
    expect_out("lu_rs2", 6'b110000);
    // address match but operand not read
    tick(); rs2_v = 1'b0;
    expect_out("lu_nouse", 6'b000000);
    // no valid decode
    tick(); rs2_v = 1'b1; dec_valid = 1'b0;
    expect_out("lu_novalid", 6'b000000);

    // Branch beats load-use; counter untouched
    tick(); dec_valid = 1'b1; branch_v = 1'b1;
    expect_out("br_lu", 6'b001000);
    tick(); clr_in();
    expect_out("br_after", 6'b000000);
    check_cnt("br_lu");
    // Trap beats mc request in RUN
    tick(); dec_valid = 1'b1; mc_req = 1'b1; trap = 1'b1;
    expect_out("trap_mcreq", 6'b001000);
    // mc_done outside MC_BUSY is ignored
    tick(); clr_in(); mc_done = 1'b1;
    expect_out("done_run", 6'b000000);
    tick(); clr_in();
    expect_out("done_run_next", 6'b000000);

    // DIV: start at cycle 0, done at cycle 33, issue at cycle 34
    tick(); dec_valid = 1'b1; mc_req = 1'b1;
    expect_out("div_start", 6'b110100);
    for (int i = 1; i <= 32; i++) begin
      tick();
      expect_out("div_busy", 6'b110000);
    end
    tick(); mc_done = 1'b1;
    expect_out("div_done", 6'b110000);
    tick(); mc_done = 1'b0;
    expect_out("div_issue", 6'b000001);
    tick(); clr_in();
    expect_out("div_after", 6'b000000);
    check_cnt("div");

    // mc request with load-use on rs2 waits one cycle, then trap at busy cycle 10
    tick(); set_mc_lu_rs2();
    expect_out("mclu_wait", 6'b110000);
    tick(); exe_load_v = 1'b0;
    expect_out("mclu_start", 6'b110100);
    for (int i = 2; i < 10; i++) begin
      tick();
      expect_out("mclu_busy", 6'b110000);
    end
    tick(); trap = 1'b1;
    expect_out("busy_trap", 6'b001010);
    tick(); clr_in(); mc_done = 1'b1;
    expect_out("late_done", 6'b000000);
    tick(); clr_in();
    expect_out("late_done_next", 6'b000000);

    // Trap and done together in MC_BUSY: trap wins
    tick(); dec_valid = 1'b1; mc_req = 1'b1;
    expect_out("td_start", 6'b110100);
    tick(); mc_done = 1'b1; trap = 1'b1;
    expect_out("trap_done", 6'b001010);
    // Stray branch in MC_BUSY acts as a trap
    tick(); clr_in(); dec_valid = 1'b1; mc_req = 1'b1;
    expect_out("bb_start", 6'b110100);
    tick(); branch_v = 1'b1;
    expect_out("busy_branch", 6'b001010);
    // Trap during MC_ISSUE
    tick(); clr_in(); dec_valid = 1'b1; mc_req = 1'b1;
    expect_out("ti_start", 6'b110100);
    tick(); mc_done = 1'b1;
    expect_out("ti_done", 6'b110000);
    tick(); mc_done = 1'b0; trap = 1'b1;
    expect_out("issue_trap", 6'b001000);
    tick(); clr_in();
    expect_out("issue_trap_next", 6'b000000);
    check_cnt("mc_mix");

    // Asynchronous reset in the middle of MC_BUSY
    tick(); dec_valid = 1'b1; mc_req = 1'b1;
    expect_out("rst_start", 6'b110100);
    tick();
    expect_out("rst_busy", 6'b110000);
    tick(); reset_n = 1'b0; exp_cnt = 0; exp_sat = 0; exp_wrap = 0;
    expect_out("rst_mid", 6'b000000);
    check_cnt("rst_mid");
    tick(); clr_in(); reset_n = 1'b1; mc_done = 1'b1;
    expect_out("rst_release", 6'b000000);

    // 20 back-to-back load-use stalls: 4-bit counters saturate at 15 / wrap to 4
    tick(); clr_in(); dec_valid = 1'b1; rs1_v = 1'b1; rs1_adr = 5'd12;
    exe_load_v = 1'b1; rd_adr = 5'd12;
    expect_out("sat_lu", 6'b110000);
    for (int i = 1; i < 20; i++) begin
      tick();
      expect_out("sat_lu", 6'b110000);
    end
    tick(); clr_in();
    expect_out("sat_after", 6'b000000);
    check_cnt("sat20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline hazard and sequencing controller for the IF/DEC/EXE front end. It detects load-use hazards between the decode stage and a load held in EXE, and sequences multi-cycle unit (DIV) operations by holding decode until the unit completes. It also generates flush/bubble controls on branch and trap. It sits beside the decode stage, driving stall inputs to ifetch and the decode flop enable, and keeps a saturating stall-cycle performance counter.

Parameters:
XLEN, 32, width of the stall performance counter
CNT_SAT, 1, 1 = stall counter saturates at all-ones; 0 = counter wraps

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
dec_valid_i  input  1  decode holds a valid instruction
dec_rs1_v_i  input  1  decode instruction reads rs1
dec_rs1_adr_i  input  5  decode rs1 address
dec_rs2_v_i  input  1  decode instruction reads rs2
dec_rs2_adr_i  input  5  decode rs2 address
dec_mc_req_i  input  1  decode instruction targets the multi-cycle unit
exe_load_v_q_i  input  1  EXE holds a load writing rd
exe_rd_adr_q_i  input  5  EXE destination register
mc_done_i  input  1  multi-cycle unit result ready (1-cycle pulse)
branch_v_q_i  input  1  taken branch resolved in EXE
trap_i  input  1  exception/interrupt taken this cycle
stall_o  output  1  hold PC, ifetch and decode registers
bubble_o  output  1  force decode outputs to a NOP (rd_v=0, csr_wbk=0) into EXE
flush_o  output  1  kill IF and DEC contents
mc_start_o  output  1  start pulse to the multi-cycle unit
mc_abort_o  output  1  abort pulse to the multi-cycle unit
mc_issue_o  output  1  multi-cycle result may be consumed by the issuing instruction this cycle
stall_cnt_q_o  output  XLEN  count of cycles with stall_o=1

Behaviour:
- States: RUN, MC_BUSY, MC_ISSUE. State is 2-bit registered. Reset: RUN, stall_cnt=0.
- All outputs except stall_cnt_q_o are combinational from state and inputs. During reset, all outputs read 0.
- Load-use hazard: lu = exe_load_v_q_i & exe_rd_adr_q_i!=0 & dec_valid_i & ((dec_rs1_v_i & rs1==rd) | (dec_rs2_v_i & rs2==rd)).
- RUN, priority high to low:
  1. branch_v_q_i|trap_i: flush_o=1, stall_o=0, bubble_o=0; stay RUN.
  2. dec_valid_i & dec_mc_req_i & ~lu: mc_start_o=1, stall_o=1, bubble_o=1; go to MC_BUSY.
  3. lu: stall_o=1, bubble_o=1 for exactly this cycle; stay RUN. The next cycle EXE holds the bubble, so lu clears. One-cycle penalty; the value is delivered by the RF fast-forward.
  4. else: all 0.
- An mc request that is also load-use waits for lu to clear first, so the operands are valid when mc_start_o fires.
- MC_BUSY: stall_o=1, bubble_o=1.
  - trap_i: flush_o=1, mc_abort_o=1, stall_o=0, bubble_o=0; go to RUN (trap has priority over mc_done_i).
  - branch_v_q_i cannot occur (EXE holds bubbles). If asserted, treat it as trap_i.
  - mc_done_i: go to MC_ISSUE.
  - No timeout; the unit guarantees completion.
- MC_ISSUE (1 cycle): stall_o=0, bubble_o=0, mc_issue_o=1, dec_mc_req_i is ignored; the instruction advances into EXE carrying the result. Go to RUN.
  - trap_i here: flush_o=1, mc_issue_o=0; go to RUN.
- mc_start_o and mc_abort_o are never both 1. mc_done_i outside MC_BUSY is ignored.
- stall_cnt: +1 on each cycle with stall_o=1.
  - CNT_SAT=1: holds at 2^XLEN-1.
  - CNT_SAT=0: wraps to 0.
- Asynchronous reset mid-operation (any state): state returns to RUN, counter to 0. No abort pulse is issued; the multi-cycle unit is reset by the same reset_n.

Test Plan:
- Load-use: exe_load_v=1, rd=5; dec rs1_v=1, rs1=5 -> stall_o=bubble_o=1 for 1 cycle, then 0; stall_cnt=1. Same with rd=0 -> no stall.
- DIV sequence: dec_mc_req=1 at cycle 0; mc_done at cycle 33 -> mc_start_o at cycle 0 only; stall_o=1 for cycles 0-33; mc_issue_o=1 at cycle 34; stall_cnt=34.
- Trap during MC_BUSY at cycle 10 -> flush_o=mc_abort_o=1 at cycle 10, state RUN at cycle 11. A later mc_done_i is ignored.
- Simultaneous branch_v_q_i and lu in RUN -> flush_o=1, stall_o=0, bubble_o=0, stall_cnt unchanged.
- mc request plus load-use on rs2 -> cycle 0: stall with no mc_start; cycle 1: mc_start_o=1.
- Counter saturation: XLEN=4, CNT_SAT=1, 20 stall cycles -> stall_cnt_q_o=15. CNT_SAT=0 -> 4. Reset asserted mid-MC_BUSY -> all outputs 0, counter 0.
